// File: rtl/branch_add_issue_queue.sv
// branch_add_issue_queue
//   In-order issue queue feeding a branch/add unit. Entries wait in a circular
//   FIFO, snoop the CDB for missing source operands, and leave from the head
//   only once both sources are ready. Issued operands are registered.
//
// Parameters: WIDTH (datapath), DEPTH (entries, power of two >= 2),
//             TAG_W (physical source tag width)
// Ports:
//   i_clk, i_rst_n (sync, active-low), i_flush (discard all entries)
//   i_enq_valid/o_enq_ready   enqueue handshake
//   i_enq_op/func/pred, i_enq_rs{1,2}_{tag,rdy,val}, i_enq_imm, i_enq_pc
//   i_cdb_valid/tag/data      result broadcast used for wakeup
//   o_start                   one-cycle issue strobe
//   o_op/func/rs1/rs2/imm/pc/pred  issued entry fields (hold when idle)
//
// Build option: BAU_IQ_WAKEUP_BYPASS_EN lets a head entry issue in the same
// cycle its last missing source arrives on the CDB, using i_cdb_data directly.
module branch_add_issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_enq_valid,
  output logic             o_enq_ready,
  input  logic             i_enq_op,
  input  logic [2:0]       i_enq_func,
  input  logic             i_enq_pred,
  input  logic [TAG_W-1:0] i_enq_rs1_tag,
  input  logic             i_enq_rs1_rdy,
  input  logic [WIDTH-1:0] i_enq_rs1_val,
  input  logic [TAG_W-1:0] i_enq_rs2_tag,
  input  logic             i_enq_rs2_rdy,
  input  logic [WIDTH-1:0] i_enq_rs2_val,
  input  logic [WIDTH-1:0] i_enq_imm,
  input  logic [WIDTH-1:0] i_enq_pc,
  input  logic             i_cdb_valid,
  input  logic [TAG_W-1:0] i_cdb_tag,
  input  logic [WIDTH-1:0] i_cdb_data,
  output logic             o_start,
  output logic             o_op,
  output logic [2:0]       o_func,
  output logic [WIDTH-1:0] o_rs1,
  output logic [WIDTH-1:0] o_rs2,
  output logic [WIDTH-1:0] o_imm,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_pred
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             e_valid   [DEPTH];
  logic             e_op      [DEPTH];
  logic [2:0]       e_func    [DEPTH];
  logic             e_pred    [DEPTH];
  logic [TAG_W-1:0] e_rs1_tag [DEPTH];
  logic             e_rs1_rdy [DEPTH];
  logic [WIDTH-1:0] e_rs1_val [DEPTH];
  logic [TAG_W-1:0] e_rs2_tag [DEPTH];
  logic             e_rs2_rdy [DEPTH];
  logic [WIDTH-1:0] e_rs2_val [DEPTH];
  logic [WIDTH-1:0] e_imm     [DEPTH];
  logic [WIDTH-1:0] e_pc      [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic             enq_fire, enq_write, empty_bypass, head_issue;
  logic             enq_rs1_rdy, enq_rs2_rdy;
  logic [WIDTH-1:0] enq_rs1_val, enq_rs2_val;
  logic             head_rs1_ok, head_rs2_ok;
  logic [WIDTH-1:0] head_rs1_val, head_rs2_val;

  always_comb begin
    o_enq_ready = (count < CNT_W'(DEPTH));
    enq_fire    = i_enq_valid && o_enq_ready;

    // Sources arriving on the CDB in the enqueue cycle are stored already ready.
    enq_rs1_rdy = i_enq_rs1_rdy || (i_cdb_valid && (i_cdb_tag == i_enq_rs1_tag));
    enq_rs2_rdy = i_enq_rs2_rdy || (i_cdb_valid && (i_cdb_tag == i_enq_rs2_tag));
    enq_rs1_val = i_enq_rs1_rdy ? i_enq_rs1_val : i_cdb_data;
    enq_rs2_val = i_enq_rs2_rdy ? i_enq_rs2_val : i_cdb_data;

    // A fully ready instruction entering an empty queue goes straight to the
    // output registers instead of spending a cycle in an entry.
    empty_bypass = enq_fire && (count == '0) && i_enq_rs1_rdy && i_enq_rs2_rdy;
    enq_write    = enq_fire && !empty_bypass;

`ifdef BAU_IQ_WAKEUP_BYPASS_EN
    head_rs1_ok = e_rs1_rdy[head] || (i_cdb_valid && (i_cdb_tag == e_rs1_tag[head]));
    head_rs2_ok = e_rs2_rdy[head] || (i_cdb_valid && (i_cdb_tag == e_rs2_tag[head]));
`else
    head_rs1_ok = e_rs1_rdy[head];
    head_rs2_ok = e_rs2_rdy[head];
`endif
    head_rs1_val = e_rs1_rdy[head] ? e_rs1_val[head] : i_cdb_data;
    head_rs2_val = e_rs2_rdy[head] ? e_rs2_val[head] : i_cdb_data;
    head_issue   = (count != '0) && e_valid[head] && head_rs1_ok && head_rs2_ok;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      o_start <= 1'b0;
      o_op    <= 1'b0;
      o_func  <= '0;
      o_rs1   <= '0;
      o_rs2   <= '0;
      o_imm   <= '0;
      o_pc    <= '0;
      o_pred  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_valid[PTR_W'(i)]   <= 1'b0;
        e_rs1_rdy[PTR_W'(i)] <= 1'b0;
        e_rs2_rdy[PTR_W'(i)] <= 1'b0;
      end
    end else if (i_flush) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      o_start <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_valid[PTR_W'(i)]   <= 1'b0;
        e_rs1_rdy[PTR_W'(i)] <= 1'b0;
        e_rs2_rdy[PTR_W'(i)] <= 1'b0;
      end
    end else begin
      o_start <= head_issue || empty_bypass;

      // Wakeup: only sources still waiting capture; ready values are frozen.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (e_valid[PTR_W'(i)] && i_cdb_valid) begin
          if (!e_rs1_rdy[PTR_W'(i)] && (e_rs1_tag[PTR_W'(i)] == i_cdb_tag)) begin
            e_rs1_rdy[PTR_W'(i)] <= 1'b1;
            e_rs1_val[PTR_W'(i)] <= i_cdb_data;
          end
          if (!e_rs2_rdy[PTR_W'(i)] && (e_rs2_tag[PTR_W'(i)] == i_cdb_tag)) begin
            e_rs2_rdy[PTR_W'(i)] <= 1'b1;
            e_rs2_val[PTR_W'(i)] <= i_cdb_data;
          end
        end
      end

      if (enq_write) begin
        e_valid[tail]   <= 1'b1;
        e_op[tail]      <= i_enq_op;
        e_func[tail]    <= i_enq_func;
        e_pred[tail]    <= i_enq_pred;
        e_rs1_tag[tail] <= i_enq_rs1_tag;
        e_rs1_rdy[tail] <= enq_rs1_rdy;
        e_rs1_val[tail] <= enq_rs1_val;
        e_rs2_tag[tail] <= i_enq_rs2_tag;
        e_rs2_rdy[tail] <= enq_rs2_rdy;
        e_rs2_val[tail] <= enq_rs2_val;
        e_imm[tail]     <= i_enq_imm;
        e_pc[tail]      <= i_enq_pc;
        tail            <= tail + PTR_W'(1);
      end

      if (head_issue) begin
        e_valid[head] <= 1'b0;
        head          <= head + PTR_W'(1);
        o_op          <= e_op[head];
        o_func        <= e_func[head];
        o_pred        <= e_pred[head];
        o_rs1         <= head_rs1_val;
        o_rs2         <= head_rs2_val;
        o_imm         <= e_imm[head];
        o_pc          <= e_pc[head];
      end else if (empty_bypass) begin
        o_op   <= i_enq_op;
        o_func <= i_enq_func;
        o_pred <= i_enq_pred;
        o_rs1  <= i_enq_rs1_val;
        o_rs2  <= i_enq_rs2_val;
        o_imm  <= i_enq_imm;
        o_pc   <= i_enq_pc;
      end

      count <= count + CNT_W'(enq_write) - CNT_W'(head_issue);
    end
  end

endmodule

// File: tb/tb_branch_add_issue_queue.sv
module tb_branch_add_issue_queue;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_enq_valid, o_enq_ready;
  logic        i_enq_op, i_enq_pred;
  logic [2:0]  i_enq_func;
  logic [4:0]  i_enq_rs1_tag, i_enq_rs2_tag, i_cdb_tag;
  logic        i_enq_rs1_rdy, i_enq_rs2_rdy, i_cdb_valid;
  logic [31:0] i_enq_rs1_val, i_enq_rs2_val, i_enq_imm, i_enq_pc, i_cdb_data;
  logic        o_start, o_op, o_pred;
  logic [2:0]  o_func;
  logic [31:0] o_rs1, o_rs2, o_imm, o_pc;

  int unsigned total  = 0;
  int unsigned passed = 0;

  branch_add_issue_queue #(.WIDTH(32), .DEPTH(4), .TAG_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
    .i_enq_op(i_enq_op), .i_enq_func(i_enq_func), .i_enq_pred(i_enq_pred),
    .i_enq_rs1_tag(i_enq_rs1_tag), .i_enq_rs1_rdy(i_enq_rs1_rdy), .i_enq_rs1_val(i_enq_rs1_val),
    .i_enq_rs2_tag(i_enq_rs2_tag), .i_enq_rs2_rdy(i_enq_rs2_rdy), .i_enq_rs2_val(i_enq_rs2_val),
    .i_enq_imm(i_enq_imm), .i_enq_pc(i_enq_pc),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .o_start(o_start), .o_op(o_op), .o_func(o_func), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_imm(o_imm), .o_pc(o_pc), .o_pred(o_pred)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_flush = 1'b0; i_enq_valid = 1'b0; i_enq_op = 1'b0; i_enq_func = '0; i_enq_pred = 1'b0;
    i_enq_rs1_tag = '0; i_enq_rs1_rdy = 1'b0; i_enq_rs1_val = '0;
    i_enq_rs2_tag = '0; i_enq_rs2_rdy = 1'b0; i_enq_rs2_val = '0;
    i_enq_imm = '0; i_enq_pc = '0;
    i_cdb_valid = 1'b0; i_cdb_tag = '0; i_cdb_data = '0;
  endtask

  task automatic enq(input logic op, input logic [2:0] func, input logic pred,
                     input logic [4:0] t1, input logic r1, input logic [31:0] v1,
                     input logic [4:0] t2, input logic r2, input logic [31:0] v2,
                     input logic [31:0] imm, input logic [31:0] pc);
    i_enq_valid = 1'b1; i_enq_op = op; i_enq_func = func; i_enq_pred = pred;
    i_enq_rs1_tag = t1; i_enq_rs1_rdy = r1; i_enq_rs1_val = v1;
    i_enq_rs2_tag = t2; i_enq_rs2_rdy = r2; i_enq_rs2_val = v2;
    i_enq_imm = imm; i_enq_pc = pc;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
    i_cdb_valid = 1'b1; i_cdb_tag = tag; i_cdb_data = data;
  endtask

  initial begin
    idle();
    i_rst_n = 1'b0;
    step(); step();
    chk("rst_start", o_start, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_rs1", o_rs1, 0);
    i_rst_n = 1'b1;
    step();
    chk("post_rst_ready", o_enq_ready, 1);
    chk("post_rst_start", o_start, 0);

    // Ready instruction into empty queue issues one cycle later
    enq(1'b1, 3'b000, 1'b1, 5'd1, 1'b1, 32'h11, 5'd2, 1'b1, 32'h22, 32'h20, 32'h100);
    step(); idle();
    chk("t1_start", o_start, 1);
    chk("t1_pc", o_pc, 32'h100);
    chk("t1_imm", o_imm, 32'h20);
    chk("t1_op", o_op, 1);
    chk("t1_pred", o_pred, 1);
    chk("t1_rs1", o_rs1, 32'h11);
    chk("t1_rs2", o_rs2, 32'h22);
    step();
    chk("t1_start_drop", o_start, 0);
    chk("t1_pc_hold", o_pc, 32'h100);

    // Fill with unready head + ready younger entries; full blocks 5th
    enq(1'b0, 3'b001, 1'b0, 5'd7, 1'b0, 32'h0, 5'd4, 1'b1, 32'h2, 32'h1, 32'h200);
    step();
    chk("fill_a_start", o_start, 0);
    chk("fill_a_ready", o_enq_ready, 1);
    enq(1'b1, 3'b010, 1'b0, 5'd5, 1'b1, 32'h33, 5'd6, 1'b1, 32'h44, 32'h2, 32'h204);
    step();
    chk("fill_b_start", o_start, 0);
    enq(1'b0, 3'b011, 1'b1, 5'd5, 1'b1, 32'h35, 5'd6, 1'b1, 32'h45, 32'h3, 32'h208);
    step();
    enq(1'b1, 3'b100, 1'b0, 5'd5, 1'b1, 32'h37, 5'd6, 1'b1, 32'h47, 32'h4, 32'h20C);
    step();
    chk("full_ready", o_enq_ready, 0);
    chk("full_start", o_start, 0);
    enq(1'b1, 3'b101, 1'b0, 5'd5, 1'b1, 32'h39, 5'd6, 1'b1, 32'h49, 32'h5, 32'h210);
    step(); idle();
    chk("full_5th_ready", o_enq_ready, 0);
    chk("full_5th_start", o_start, 0);

    // Wake head rs1 via CDB
    cdb(5'd7, 32'hDEAD);
    step(); idle();
`ifdef BAU_IQ_WAKEUP_BYPASS_EN
    chk("wake_start_n1", o_start, 1);
`else
    chk("wake_start_n1", o_start, 0);
    step();
    chk("wake_start_n2", o_start, 1);
`endif
    chk("wake_rs1", o_rs1, 32'hDEAD);
    chk("wake_pc", o_pc, 32'h200);
    chk("wake_func", o_func, 3'b001);
    chk("drain_ready", o_enq_ready, 1);
    // Enqueue F while B issues
    enq(1'b0, 3'b110, 1'b0, 5'd5, 1'b1, 32'h3B, 5'd6, 1'b1, 32'h4B, 32'h6, 32'h214);
    step(); idle();
    chk("drain_b_start", o_start, 1);
    chk("drain_b_pc", o_pc, 32'h204);
    chk("drain_b_rs1", o_rs1, 32'h33);
    step();
    chk("drain_c_pc", o_pc, 32'h208);
    chk("drain_c_pred", o_pred, 1);
    step();
    chk("drain_d_pc", o_pc, 32'h20C);
    chk("drain_d_start", o_start, 1);
    step();
    chk("drain_f_pc", o_pc, 32'h214);
    chk("drain_f_rs2", o_rs2, 32'h4B);
    step();
    chk("drain_empty_start", o_start, 0);
    chk("drain_empty_pc", o_pc, 32'h214);

    // Enqueue-time CDB forwarding into rs2
    enq(1'b1, 3'b111, 1'b0, 5'd8, 1'b1, 32'h66, 5'd3, 1'b0, 32'h0, 32'h7, 32'h300);
    cdb(5'd3, 32'h55);
    step(); idle();
    chk("fwd_start0", o_start, 0);
    step();
    chk("fwd_start1", o_start, 1);
    chk("fwd_rs2", o_rs2, 32'h55);
    chk("fwd_pc", o_pc, 32'h300);
    step();

    // Later CDB matches must not overwrite a captured source
    enq(1'b0, 3'b000, 1'b0, 5'd9, 1'b0, 32'h0, 5'd10, 1'b0, 32'h0, 32'h8, 32'h400);
    step(); idle();
    cdb(5'd9, 32'hAAAA);
    step(); idle();
    chk("keep_wait1", o_start, 0);
    cdb(5'd9, 32'hBBBB);
    step(); idle();
    chk("keep_wait2", o_start, 0);
    cdb(5'd10, 32'hCCCC);
    step(); idle();
`ifndef BAU_IQ_WAKEUP_BYPASS_EN
    chk("keep_wait3", o_start, 0);
    step();
`endif
    chk("keep_start", o_start, 1);
    chk("keep_rs1", o_rs1, 32'hAAAA);
    chk("keep_rs2", o_rs2, 32'hCCCC);
    step();

    // Flush with 3 entries plus same-cycle enqueue and head wakeup
    enq(1'b0, 3'b000, 1'b0, 5'd12, 1'b0, 32'h0, 5'd4, 1'b1, 32'h1, 32'h0, 32'h500);
    step();
    enq(1'b0, 3'b000, 1'b0, 5'd4, 1'b1, 32'h1, 5'd4, 1'b1, 32'h1, 32'h0, 32'h504);
    step();
    enq(1'b0, 3'b000, 1'b0, 5'd4, 1'b1, 32'h1, 5'd4, 1'b1, 32'h1, 32'h0, 32'h508);
    step();
    enq(1'b0, 3'b000, 1'b0, 5'd4, 1'b1, 32'h1, 5'd4, 1'b1, 32'h1, 32'h0, 32'h50C);
    cdb(5'd12, 32'h77);
    i_flush = 1'b1;
    step(); idle();
    chk("flush_start", o_start, 0);
    chk("flush_ready", o_enq_ready, 1);
    step();
    chk("flush_start2", o_start, 0);
    enq(1'b1, 3'b010, 1'b0, 5'd4, 1'b1, 32'h61, 5'd4, 1'b1, 32'h62, 32'h0, 32'h600);
    step(); idle();
    chk("flush_empty_start", o_start, 1);
    chk("flush_empty_pc", o_pc, 32'h600);

    // Reset mid-operation discards entries
    enq(1'b0, 3'b000, 1'b0, 5'd13, 1'b0, 32'h0, 5'd4, 1'b1, 32'h1, 32'h0, 32'h700);
    step();
    enq(1'b0, 3'b000, 1'b0, 5'd4, 1'b1, 32'h1, 5'd4, 1'b1, 32'h1, 32'h0, 32'h704);
    step(); idle();
    cdb(5'd13, 32'h99);
    i_rst_n = 1'b0;
    step(); idle();
    chk("mid_rst_start", o_start, 0);
    chk("mid_rst_pc", o_pc, 0);
    i_rst_n = 1'b1;
    step();
    chk("mid_rst_ready", o_enq_ready, 1);
    chk("mid_rst_start2", o_start, 0);
    cdb(5'd13, 32'h99);
    step(); idle();
    step();
    chk("mid_rst_no_issue", o_start, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
